// File: rtl/mem_model_param.sv
// mem_model_param
// Single-port behavioural memory model with a select/valid handshake.
// Width, depth and response latency are configurable. Supports per-byte
// write enables, a busy indication and an out-of-range error response.
// Only one request is outstanding at a time, and every accepted request
// gets exactly one single-cycle outputValid pulse.
//
// Ports:
//   clk           rising-edge clock
//   rst           synchronous reset, active-high (memory contents untouched)
//   inputAddress  word address
//   inputWdata    write data
//   inputByteEn   write byte enables, bit i covers bits [8i+7:8i]
//   inputWnR      1 = write, 0 = read
//   inputSelect   request strobe; accepted when !outputBusy
//   outputRdata   read data, nonzero only in the response cycle of an in-range read
//   outputValid   one-cycle response pulse
//   outputError   response is for an address >= DEPTH
//   outputBusy    request in flight or response being presented
module mem_model_param #(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 16,
  parameter int DEPTH   = 4096,
  parameter int LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_W-1:0]     inputAddress,
  input  logic [DATA_W-1:0]     inputWdata,
  input  logic [DATA_W/8-1:0]   inputByteEn,
  input  logic                  inputWnR,
  input  logic                  inputSelect,
  output logic [DATA_W-1:0]     outputRdata,
  output logic                  outputValid,
  output logic                  outputError,
  output logic                  outputBusy
);

  localparam int BE_W  = DATA_W / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [3:0]      CNT_INIT = 4'(LATENCY - 1);
  // One extra bit so DEPTH == 2**ADDR_W is representable.
  localparam logic [ADDR_W:0] DEPTH_W  = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [1:0]        state_q, state_d;
  logic [3:0]        cnt_q,   cnt_d;
  logic              wnr_q,   wnr_d;
  logic              err_q,   err_d;
  logic [DATA_W-1:0] hold_q,  hold_d;

  logic              accept;
  logic              in_range;
  logic [IDX_W-1:0]  idx;

  assign outputBusy  = (state_q != S_IDLE);
  assign outputValid = (state_q == S_RESP);
  assign outputError = outputValid && err_q;
  assign outputRdata = (outputValid && !wnr_q && !err_q) ? hold_q : '0;

  // rst has priority over acceptance through the reset branch below; the
  // memory write is gated by !rst explicitly because it sits outside it.
  assign accept   = inputSelect && !outputBusy;
  assign in_range = ({1'b0, inputAddress} < DEPTH_W);
  assign idx      = inputAddress[IDX_W-1:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wnr_d   = wnr_q;
    err_d   = err_q;
    hold_d  = hold_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          cnt_d   = CNT_INIT;
          state_d = (LATENCY == 1) ? S_RESP : S_WAIT;
          wnr_d   = inputWnR;
          err_d   = !in_range;
          // Sampling at accept gives read-before-any-later-write semantics.
          hold_d  = (in_range && !inputWnR) ? mem[idx] : '0;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = S_RESP;
      end
      S_RESP: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      wnr_q   <= 1'b0;
      err_q   <= 1'b0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wnr_q   <= wnr_d;
      err_q   <= err_d;
      hold_q  <= hold_d;
    end
  end

  // Storage is not reset; writes commit at the accept edge.
  always_ff @(posedge clk) begin
    if (!rst && accept && inputWnR && in_range) begin
      for (int b = 0; b < BE_W; b++) begin
        if (inputByteEn[b]) mem[idx][8*b +: 8] <= inputWdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_mem_model_param.sv
module tb_mem_model_param;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // u1: LATENCY=1, 16-bit, 4096 words
  logic [11:0] a1 = '0;  logic [15:0] d1 = '0; logic [1:0] be1 = '0;
  logic        w1 = 0;   logic        s1 = 0;
  logic [15:0] rd1; logic v1, er1, bz1;
  // u4: LATENCY=4, 32-bit, 1000 words
  logic [11:0] a4 = '0;  logic [31:0] d4 = '0; logic [3:0] be4 = '0;
  logic        w4 = 0;   logic        s4 = 0;
  logic [31:0] rd4; logic v4, er4, bz4;
  // u3: LATENCY=3, 16-bit, 4096 words
  logic [11:0] a3 = '0;  logic [15:0] d3 = '0; logic [1:0] be3 = '0;
  logic        w3 = 0;   logic        s3 = 0;
  logic [15:0] rd3; logic v3, er3, bz3;

  mem_model_param #(.ADDR_W(12), .DATA_W(16), .DEPTH(4096), .LATENCY(1)) u1 (
    .clk(clk), .rst(rst), .inputAddress(a1), .inputWdata(d1), .inputByteEn(be1),
    .inputWnR(w1), .inputSelect(s1), .outputRdata(rd1), .outputValid(v1),
    .outputError(er1), .outputBusy(bz1));
  mem_model_param #(.ADDR_W(12), .DATA_W(32), .DEPTH(1000), .LATENCY(4)) u4 (
    .clk(clk), .rst(rst), .inputAddress(a4), .inputWdata(d4), .inputByteEn(be4),
    .inputWnR(w4), .inputSelect(s4), .outputRdata(rd4), .outputValid(v4),
    .outputError(er4), .outputBusy(bz4));
  mem_model_param #(.ADDR_W(12), .DATA_W(16), .DEPTH(4096), .LATENCY(3)) u3 (
    .clk(clk), .rst(rst), .inputAddress(a3), .inputWdata(d3), .inputByteEn(be3),
    .inputWnR(w3), .inputSelect(s3), .outputRdata(rd3), .outputValid(v3),
    .outputError(er3), .outputBusy(bz3));

  // Each request task issues one request, waits (bounded) for the response
  // and reports cycles-to-valid (0 = timeout), response data/error, and the
  // valid level one cycle after the pulse.
  task automatic req1(input logic [11:0] a, input logic [15:0] d, input logic [1:0] be,
                      input logic w, output int lat, output logic [15:0] rd,
                      output logic er, output logic va);
    @(negedge clk); a1 = a; d1 = d; be1 = be; w1 = w; s1 = 1'b1;
    @(posedge clk);
    @(negedge clk); s1 = 1'b0;
    lat = 0; rd = '0; er = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      if (v1) begin lat = k; rd = rd1; er = er1; break; end
      @(negedge clk);
    end
    @(negedge clk); va = v1;
  endtask

  task automatic req4(input logic [11:0] a, input logic [31:0] d, input logic [3:0] be,
                      input logic w, output int lat, output logic [31:0] rd,
                      output logic er, output logic va);
    @(negedge clk); a4 = a; d4 = d; be4 = be; w4 = w; s4 = 1'b1;
    @(posedge clk);
    @(negedge clk); s4 = 1'b0;
    lat = 0; rd = '0; er = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      if (v4) begin lat = k; rd = rd4; er = er4; break; end
      @(negedge clk);
    end
    @(negedge clk); va = v4;
  endtask

  task automatic req3(input logic [11:0] a, input logic [15:0] d, input logic [1:0] be,
                      input logic w, output int lat, output logic [15:0] rd,
                      output logic er, output logic va);
    @(negedge clk); a3 = a; d3 = d; be3 = be; w3 = w; s3 = 1'b1;
    @(posedge clk);
    @(negedge clk); s3 = 1'b0;
    lat = 0; rd = '0; er = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      if (v3) begin lat = k; rd = rd3; er = er3; break; end
      @(negedge clk);
    end
    @(negedge clk); va = v3;
  endtask

  task automatic test_reset();
    int lat; logic [15:0] rd; logic er, va;
    req1(12'h020, 16'h1111, 2'b11, 1'b1, lat, rd, er, va);
    @(negedge clk);
    rst = 1'b1; s1 = 1'b1; w1 = 1'b1; a1 = 12'h020; d1 = 16'h5555; be1 = 2'b11;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); @(negedge clk);
      tests++;
      if ({v1, er1, bz1, rd1} !== 19'd0) begin
        fails++;
        $display("FAIL reset_outputs cyc%0d: v=%b er=%b bz=%b rd=%h, want all 0", c, v1, er1, bz1, rd1);
      end
    end
    rst = 1'b0; s1 = 1'b0;
    @(negedge clk);
    tests++;
    if (bz1 !== 1'b0) begin fails++; $display("FAIL reset_busy_after: got %b want 0", bz1); end
    req1(12'h020, 16'h0, 2'b00, 1'b0, lat, rd, er, va);
    tests++;
    if (rd !== 16'h1111) begin fails++; $display("FAIL reset_no_write: rd=%h want 1111", rd); end
  endtask

  task automatic test_l1_basic();
    int lat; logic [15:0] rd; logic er, va;
    req1(12'h00A, 16'hBEEF, 2'b11, 1'b1, lat, rd, er, va);
    tests++;
    if (lat !== 1 || rd !== 16'h0 || er !== 1'b0 || va !== 1'b0) begin
      fails++; $display("FAIL l1_write: lat=%0d rd=%h er=%b va=%b want 1/0000/0/0", lat, rd, er, va);
    end
    req1(12'h00A, 16'h0, 2'b00, 1'b0, lat, rd, er, va);
    tests++;
    if (lat !== 1 || rd !== 16'hBEEF || er !== 1'b0 || va !== 1'b0) begin
      fails++; $display("FAIL l1_read: lat=%0d rd=%h er=%b va=%b want 1/beef/0/0", lat, rd, er, va);
    end
  endtask

  task automatic test_l1_stream();
    logic [7:0] got, want;
    want = 8'b01010101;  // bit k-1 = valid in cycle k after the first accept
    got  = '0;
    @(negedge clk); a1 = 12'h00A; w1 = 1'b0; s1 = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk); got[k] = v1;
    end
    s1 = 1'b0;
    @(negedge clk); @(negedge clk);
    tests++;
    if (got !== want) begin fails++; $display("FAIL l1_stream: valid pattern %b want %b", got, want); end
  endtask

  task automatic test_byte_en();
    int lat; logic [15:0] rd; logic er, va;
    req1(12'h090, 16'h1234, 2'b11, 1'b1, lat, rd, er, va);
    req1(12'h090, 16'hABCD, 2'b01, 1'b1, lat, rd, er, va);
    req1(12'h090, 16'h0, 2'b00, 1'b0, lat, rd, er, va);
    tests++;
    if (rd !== 16'h12CD) begin fails++; $display("FAIL be_low: rd=%h want 12cd", rd); end
    req1(12'h090, 16'hFFFF, 2'b00, 1'b1, lat, rd, er, va);
    tests++;
    if (lat !== 1) begin fails++; $display("FAIL be_none_resp: lat=%0d want 1", lat); end
    req1(12'h090, 16'h0, 2'b00, 1'b0, lat, rd, er, va);
    tests++;
    if (rd !== 16'h12CD) begin fails++; $display("FAIL be_none: rd=%h want 12cd", rd); end
    req1(12'h090, 16'h5600, 2'b10, 1'b1, lat, rd, er, va);
    req1(12'h090, 16'h0, 2'b00, 1'b0, lat, rd, er, va);
    tests++;
    if (rd !== 16'h56CD) begin fails++; $display("FAIL be_high: rd=%h want 56cd", rd); end
  endtask

  task automatic test_l4_range();
    int lat; logic [31:0] rd; logic er, va;
    req4(12'h3E8, 32'h0, 4'h0, 1'b0, lat, rd, er, va);
    tests++;
    if (lat !== 4 || er !== 1'b1 || rd !== 32'h0 || va !== 1'b0) begin
      fails++; $display("FAIL l4_oor_read: lat=%0d er=%b rd=%h va=%b want 4/1/0/0", lat, er, rd, va);
    end
    req4(12'h3E7, 32'hDEADBEEF, 4'hF, 1'b1, lat, rd, er, va);
    tests++;
    if (lat !== 4 || er !== 1'b0 || rd !== 32'h0) begin
      fails++; $display("FAIL l4_write: lat=%0d er=%b rd=%h want 4/0/0", lat, er, rd);
    end
    req4(12'h3E7, 32'h0, 4'h0, 1'b0, lat, rd, er, va);
    tests++;
    if (lat !== 4 || er !== 1'b0 || rd !== 32'hDEADBEEF) begin
      fails++; $display("FAIL l4_read: lat=%0d er=%b rd=%h want 4/0/deadbeef", lat, er, rd);
    end
    req4(12'hFFF, 32'h12345678, 4'hF, 1'b1, lat, rd, er, va);
    tests++;
    if (lat !== 4 || er !== 1'b1 || rd !== 32'h0) begin
      fails++; $display("FAIL l4_oor_write: lat=%0d er=%b rd=%h want 4/1/0", lat, er, rd);
    end
  endtask

  task automatic test_busy();
    int lat, pulses; logic [15:0] rd; logic er, va; logic [2:0] vp;
    req3(12'h012, 16'h0BAD, 2'b11, 1'b1, lat, rd, er, va);
    tests++;
    if (lat !== 3) begin fails++; $display("FAIL l3_latency: lat=%0d want 3", lat); end
    @(negedge clk); a3 = 12'h010; d3 = 16'h1234; be3 = 2'b11; w3 = 1'b1; s3 = 1'b1;
    @(posedge clk);
    @(negedge clk); vp[0] = v3; a3 = 12'h011; w3 = 1'b0; d3 = 16'hFFFF;
    @(negedge clk); vp[1] = v3; a3 = 12'h012; w3 = 1'b1;
    @(negedge clk); vp[2] = v3; s3 = 1'b0;
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk); if (v3) pulses++;
    end
    tests++;
    if (vp !== 3'b100 || pulses !== 0) begin
      fails++; $display("FAIL busy_pulses: pattern=%b extra=%0d want 100/0", vp, pulses);
    end
    req3(12'h010, 16'h0, 2'b00, 1'b0, lat, rd, er, va);
    tests++;
    if (rd !== 16'h1234) begin fails++; $display("FAIL busy_first: rd=%h want 1234", rd); end
    req3(12'h012, 16'h0, 2'b00, 1'b0, lat, rd, er, va);
    tests++;
    if (rd !== 16'h0BAD) begin fails++; $display("FAIL busy_ignored: rd=%h want 0bad", rd); end
  endtask

  task automatic test_reset_mid();
    int lat, pulses; logic [31:0] rd; logic er, va;
    req4(12'h005, 32'hCAFEF00D, 4'hF, 1'b1, lat, rd, er, va);
    @(negedge clk); a4 = 12'h005; w4 = 1'b0; s4 = 1'b1;
    @(posedge clk);
    @(negedge clk); s4 = 1'b0; rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    tests++;
    if (bz4 !== 1'b0) begin fails++; $display("FAIL rstmid_busy: got %b want 0", bz4); end
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk); if (v4) pulses++;
    end
    tests++;
    if (pulses !== 0) begin fails++; $display("FAIL rstmid_pulse: %0d pulses want 0", pulses); end
    req4(12'h005, 32'h0, 4'h0, 1'b0, lat, rd, er, va);
    tests++;
    if (lat !== 4 || rd !== 32'hCAFEF00D) begin
      fails++; $display("FAIL rstmid_read: lat=%0d rd=%h want 4/cafef00d", lat, rd);
    end
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    test_reset();
    test_l1_basic();
    test_l1_stream();
    test_byte_en();
    test_l4_range();
    test_busy();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/mem_model_param.md
# mem_model_param

Parametrised single-port behavioural memory model with a select/valid handshake, used by the S1 testbenches as instruction/data memory for the CPU under test. It generalises the fixed 4K x 16 model to configurable width, depth and read/write latency. It adds per-byte write enables, a busy indication and an out-of-range error response. One request is outstanding at a time; every accepted request, read or write, gets exactly one single-cycle valid pulse.

## Interface
Parameters:
- ADDR_W, 12, address width in words.
- DATA_W, 16, data width; must be a multiple of 8.
- DEPTH, 4096, number of implemented words; must be ≤ 2^ADDR_W.
- LATENCY, 1, cycles from accept to outputValid; legal range 1..8.

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous reset, active-high
- inputAddress  input  ADDR_W  word address
- inputWdata  input  DATA_W  write data
- inputByteEn  input  DATA_W/8  write byte enables; bit i covers bits [8i+7:8i]
- inputWnR  input  1  1 = write, 0 = read
- inputSelect  input  1  request strobe
- outputRdata  output  DATA_W  read data; valid only with outputValid
- outputValid  output  1  one-cycle response pulse
- outputError  output  1  qualifies outputValid; address ≥ DEPTH
- outputBusy  output  1  request in flight or response being presented

## Operation
- Accept condition: inputSelect && !outputBusy, sampled at the rising edge.
- outputBusy is combinational: pending || outputValid.
- On accept, address, WnR and the range check are captured, and a latency counter loads LATENCY-1.
- Write, in range: at the accept edge, mem[addr] is updated for the bytes whose inputByteEn bit is set. Other bytes are kept. inputByteEn == 0 is a legal no-op write.
- Read, in range: mem[addr] is sampled at the accept edge into a hold register. This gives read-before-any-later-write semantics.
- Out of range (addr ≥ DEPTH): there is no memory access. The response carries outputError=1 and outputRdata=0.
- State machine:
  - IDLE: on accept, go to WAIT, or to RESP if LATENCY==1.
  - WAIT: decrement the counter each cycle; go to RESP when the counter reaches 1.
  - RESP: outputValid=1 for this cycle only, then return to IDLE.
- outputRdata is driven with the hold register only in the RESP cycle, and only for reads. It is 0 in every other cycle, including write responses.
- outputError is 0 except in a RESP cycle for an out-of-range request.
- inputSelect held high continuously: a new request is accepted every LATENCY+1 cycles.
- Changes on request inputs while busy are ignored; nothing is queued.
- Memory contents are not affected by rst and start as X. Testbenches preload via hierarchical access or $readmemh.

## Timing
- Reset values: outputValid=0, outputError=0, outputRdata=0, outputBusy=0, state IDLE, counter 0.
- Request accepted at edge of cycle c → outputValid high during cycle c+LATENCY. The earliest next accept is the edge of cycle c+LATENCY+1.
- LATENCY=1 with select held high: valid toggles 1,0,1,0…, which is identical to the legacy model.
- A write is visible to a read accepted at any later edge.
- rst asserted mid-operation: the pending request is discarded and no valid pulse is produced. A write already committed at accept stays in memory. The first accept is possible at the first edge with rst low.
- rst and inputSelect high on the same edge: rst wins and the request is not accepted.

## Test plan
- Reset: hold rst 3 cycles with inputSelect=1 → all outputs 0, no memory write, outputBusy=0 after release.
- LATENCY=1, DATA_W=16:
  - write 0xBEEF to 0x0A with inputByteEn=2'b11, then read 0x0A → valid one cycle after each accept, rdata=0xBEEF, error=0.
  - with select held high, valid alternates every cycle.
- Byte enables: mem[0x90]=0x1234, then write 0xABCD with inputByteEn=2'b01 → read returns 0x12CD. Write with inputByteEn=2'b00 → unchanged.
- LATENCY=4, DATA_W=32, DEPTH=1000:
  - read 0x3E8 → valid exactly 4 cycles after accept, error=1, rdata=0.
  - read 0x3E7 after write 0xDEADBEEF → rdata=0xDEADBEEF.
- Busy handling, LATENCY=3: toggle inputAddress and inputWnR while busy → only the first request takes effect. Exactly one valid pulse per accept.
- Reset mid-read, LATENCY=4: rst one cycle after accept → no valid pulse. The next read of the same address returns its stored value.
